// File: rtl/net_resolve_pkg.sv
// Shared types, defaults and the per-bit wire resolution rule for net_resolve_pipe.
// NET_RESOLVE_XPROP_EN selects full 4-state resolution; otherwise a 2-state model is built.
package net_resolve_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefNdrv  = 4;
  localparam int unsigned DefDepth = 2;
  localparam int unsigned DefCntW  = 8;

  typedef enum logic [1:0] {
    ModeTri  = 2'b00,
    ModeWand = 2'b01,
    ModeWor  = 2'b10,
    ModeTri1 = 2'b11
  } mode_e;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } state_e;

  // has0/has1/hasx summarise the enabled, non-z contributions seen on one bit.
  function automatic logic resolve_bit(mode_e m, logic has0, logic has1, logic hasx);
    logic r;
    logic none;
    none = !(has0 || has1 || hasx);
`ifdef NET_RESOLVE_XPROP_EN
    unique case (m)
      ModeTri, ModeTri1: begin
        if (none)                       r = (m == ModeTri1) ? 1'b1 : 1'bz;
        else if (hasx || (has0 && has1)) r = 1'bx;
        else                            r = has1;
      end
      ModeWand: begin
        if (none)      r = 1'bz;
        else if (has0) r = 1'b0;
        else if (hasx) r = 1'bx;
        else           r = 1'b1;
      end
      default: begin
        if (none)      r = 1'bz;
        else if (has1) r = 1'b1;
        else if (hasx) r = 1'bx;
        else           r = 1'b0;
      end
    endcase
`else
    unique case (m)
      ModeTri:  r = !none && has1 && !has0;
      ModeTri1: r = none || (has1 && !has0);
      ModeWand: r = !none && !has0;
      default:  r = !none && has1;
    endcase
`endif
    return r;
  endfunction

endpackage

// File: rtl/net_resolve_fifo.sv
// Valid/ready FIFO holding resolved words; head is read combinationally from storage.
// No bypass: a push into a full FIFO is refused even if a pop happens that cycle.
module net_resolve_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]               count_q;
  logic                        do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/net_resolve_pipe.sv
// Resolves NDRV tri-state driver words with tri/wand/wor/tri1 semantics into a valid/ready FIFO,
// counting contention and optionally halting intake. NET_RESOLVE_XPROP_EN enables 4-state rules.
module net_resolve_pipe
  import net_resolve_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NDRV  = DefNdrv,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NDRV-1:0]            drv_en,
  input  logic [NDRV-1:0][WIDTH-1:0] drv_data,
  input  logic [1:0]                 mode,
  input  logic                       halt_en,
  input  logic                       clr_halt,
  input  logic                       cnt_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [WIDTH-1:0]           out_xmask,
  output logic                       out_conf,
  output logic [CNT_W-1:0]           conflict_cnt,
  output logic                       halted
);

  localparam int unsigned EntW = 2 * WIDTH + 1;

  mode_e              mode_m;
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   res_data, res_xmask;
  logic               res_conf;
  logic               h0, h1, hx;
  logic               fifo_full, fifo_empty, accept, conf_acc;
  logic [EntW-1:0]    fifo_head;

  assign mode_m = mode_e'(mode);

  always_comb begin
    res_data  = '0;
    res_xmask = '0;
    res_conf  = 1'b0;
    h0 = 1'b0;
    h1 = 1'b0;
    hx = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      h0 = 1'b0;
      h1 = 1'b0;
      hx = 1'b0;
      for (int i = 0; i < NDRV; i++) begin
        if (drv_en[i]) begin
`ifdef NET_RESOLVE_XPROP_EN
          if (drv_data[i][b] === 1'b0)      h0 = 1'b1;
          else if (drv_data[i][b] === 1'b1) h1 = 1'b1;
          else if (drv_data[i][b] === 1'bx) hx = 1'b1;
`else
          // x/z read as 0 in the 2-state model.
          if (drv_data[i][b] === 1'b1) h1 = 1'b1;
          else                         h0 = 1'b1;
`endif
        end
      end
      res_data[b] = resolve_bit(mode_m, h0, h1, hx);
`ifdef NET_RESOLVE_XPROP_EN
      res_xmask[b] = (res_data[b] === 1'bx);
`endif
      if ((mode_m == ModeTri || mode_m == ModeTri1) && h0 && h1) res_conf = 1'b1;
    end
  end

  assign in_ready = !fifo_full && (state_q == StRun) && !rst;
  assign accept   = in_valid && in_ready;
  assign conf_acc = accept && res_conf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun:   if (conf_acc && halt_en) state_q <= StHalt;
        StHalt:  if (clr_halt) state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= conf_acc ? CNT_W'(1) : '0;
    end else if (conf_acc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  net_resolve_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data ({res_data, res_xmask, res_conf}),
    .pop       (out_valid && out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign out_valid                        = !fifo_empty;
  assign {out_data, out_xmask, out_conf}  = fifo_head;
  assign conflict_cnt                     = cnt_q;
  assign halted                           = (state_q == StHalt);

endmodule
